// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: shifts a latched bit pattern into a pair-detector FSM and counts its dout pulses
module fsm_seq_ctrl #(
  parameter int W  = 16,
  parameter int CW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  pat,
  input  logic [CW-1:0] len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] hits,
  output logic          fsm_rst,
  output logic          fsm_din,
  input  logic          fsm_dout
);
  typedef enum logic [1:0] {IDLE, WARM, SHIFT, DONE} state_t;
  state_t        state;
  logic [W-1:0]  pat_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] idx;
  logic          last;
  assign last = idx == len_q - CW'(1);
  // Sequencer: pat_q shifts right each SHIFT cycle so bit 0 is always the bit on fsm_din
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hits  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pat_q <= pat;
          len_q <= (len > CW'(W)) ? CW'(W) : len;
          idx   <= '0;
          hits  <= '0;
          state <= WARM;
        end
        WARM: begin
          state <= abort ? IDLE : ((len_q != '0) ? SHIFT : DONE);
          if (abort) hits <= '0;
        end
        SHIFT: if (abort) begin
          state <= IDLE;
          hits  <= '0;
        end else begin
          pat_q <= pat_q >> 1;
          idx   <= idx + CW'(1);
          hits  <= hits + CW'(fsm_dout);
          if (last) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Outputs decode registered state only; controller reset forces the detector into reset
  always_comb begin
    busy    = rst_n && (state == WARM || state == SHIFT);
    done    = rst_n && state == DONE;
    fsm_rst = !rst_n || state == IDLE || state == DONE;
    fsm_din = rst_n && state == SHIFT && pat_q[0];
  end
endmodule
